// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter merging N_INPUTS ready/valid packet streams into one
// registered ready/valid output. A grant is held until the granted requester
// transfers its last beat; the next search starts just past the last winner.
module rv_rr_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(N_INPUTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [N_INPUTS-1:0]            in_last,
    output logic [N_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]          data,
    output logic                           data_valid,
    output logic                           data_last,
    output logic [ID_WIDTH-1:0]            data_id,
    input  logic                           data_ready
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;

    logic [N_INPUTS-1:0][DATA_WIDTH-1:0] in_beat;
    logic                    out_free;
    logic                    in_xfer;
    logic                    found;
    logic [ID_WIDTH-1:0]     winner;
    logic [ID_WIDTH-1:0]     idx;

    assign in_beat  = in_data;
    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !valid_q || data_ready;
    assign in_xfer  = |(in_valid & in_ready);

    assign data       = data_q;
    assign data_valid = valid_q;
    assign data_last  = last_q;
    assign data_id    = id_q;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + k) % N_INPUTS);
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Only the granted requester sees ready, and only while the output can accept.
    always_comb begin
        in_ready = '0;
        if (state_q == BUSY && reset)
            in_ready[grant_q] = out_free;
    end

    // Next-state for the grant FSM and the output register.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        id_d     = id_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && in_last[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == ID_WIDTH'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat overwrites a draining one; otherwise a drain empties the register.
        if (in_xfer) begin
            data_d  = in_beat[grant_q];
            last_d  = in_last[grant_q];
            id_d    = grant_q;
            valid_d = 1'b1;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            id_q     <= id_d;
        end
    end

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Bench for rv_rr_arbiter: randomized packet sources, a packet-level
// round-robin reference model feeding a scoreboard, and a decoupled monitor.
module tb_rv_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   data;
    logic            data_valid;
    logic            data_last;
    logic [IW-1:0]   data_id;
    logic            data_ready = 1'b0;

    rv_rr_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .data(data), .data_valid(data_valid), .data_last(data_last), .data_id(data_id),
        .data_ready(data_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [IW-1:0] id;
    } beat_t;

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [N][$];   // {last, data} per beat, per source
    int         pos [N];        // driver progress
    int         exp_pos [N];    // model progress
    beat_t      sb [$];

    bit drv_en = 0;
    bit mon_en = 0;
    int gap_pct = 0, rdy_pct = 100, stall_lo = -1, stall_hi = -1, phase_start = 0;

    // reference model: packet-level view of who owns the output and register fill
    bit m_busy = 0, m_occ = 0, m_in, found;
    int m_grant = 0, m_ptr = 0, w;
    logic [8:0]   b, db;
    beat_t        e, prev;
    bit           prev_stall = 0;
    logic [N-1:0] er, xfer_seen = '0;

    int first_dv_cyc, first_out_cyc, last_out_cyc, nout, rdy2_cnt, start_cyc;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor + model: compare at negedge, then advance the model for the coming edge.
    initial forever begin
        @(negedge clock);
        xfer_seen = in_valid & in_ready;
        if (mon_en && reset) begin
            er = '0;
            if (m_busy && (!m_occ || data_ready)) er[m_grant] = 1'b1;
            chk("in_ready", int'(in_ready), int'(er));
            chk("data_valid", int'(data_valid), int'(m_occ));
            if (prev_stall) begin
                chk("hold_data", int'(data), int'(prev.d));
                chk("hold_last", int'(data_last), int'(prev.l));
                chk("hold_id", int'(data_id), int'(prev.id));
            end
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(data), -1);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", int'(data), int'(e.d));
                    chk("beat_last", int'(data_last), int'(e.l));
                    chk("beat_id", int'(data_id), int'(e.id));
                end
                nout++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            if (data_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
            if (in_ready[2]) rdy2_cnt++;
            prev_stall = data_valid && !data_ready;
            prev.d = data; prev.l = data_last; prev.id = data_id;

            m_in = m_busy && in_valid[m_grant] && (!m_occ || data_ready);
            if (m_in) m_occ = 1;
            else if (m_occ && data_ready) m_occ = 0;
            if (m_busy) begin
                if (m_in && in_last[m_grant]) begin
                    m_busy = 0;
                    m_ptr  = (m_grant + 1) % N;
                end
            end else if (|in_valid) begin
                found = 0; w = 0;
                for (int k = 0; k < N; k++)
                    if (!found && in_valid[(m_ptr + k) % N]) begin
                        found = 1; w = (m_ptr + k) % N;
                    end
                m_busy = 1; m_grant = w;
                // whole packet is owed to the output, contiguously
                do begin
                    b = src_q[w][exp_pos[w]];
                    exp_pos[w]++;
                    e.d = b[7:0]; e.l = b[8]; e.id = w[IW-1:0];
                    sb.push_back(e);
                end while (!b[8] && exp_pos[w] < src_q[w].size());
            end
        end else begin
            prev_stall = 0;
            if (!reset) begin m_busy = 0; m_ptr = 0; m_occ = 0; end
        end
    end

    // Source driver: each source presents its beats in order, holding until accepted.
    initial forever begin
        @(posedge clock); #1;
        if (drv_en) begin
            for (int i = 0; i < N; i++) begin
                if (xfer_seen[i]) begin pos[i]++; in_valid[i] = 1'b0; end
                if (!in_valid[i] && pos[i] < src_q[i].size() && $urandom_range(99) >= gap_pct) begin
                    db = src_q[i][pos[i]];
                    in_data[i*DW +: DW] = db[7:0];
                    in_last[i] = db[8];
                    in_valid[i] = 1'b1;
                    if (start_cyc < 0) start_cyc = cyc;
                end
            end
            if ((cyc - phase_start) >= stall_lo && (cyc - phase_start) < stall_hi) data_ready = 1'b0;
            else data_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic do_reset();
        @(posedge clock); #2;
        drv_en = 0; reset = 1'b0; in_valid = '0; data_ready = 1'b0; sb.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic add_pkt(input int s, input int len, input int base, input bit rnd);
        for (int k = 0; k < len; k++)
            src_q[s].push_back({(k == len - 1), rnd ? 8'($urandom_range(255)) : 8'(base + k * 'h11)});
    endtask

    function automatic bit phase_done();
        for (int i = 0; i < N; i++)
            if (pos[i] < src_q[i].size() || exp_pos[i] < src_q[i].size()) return 0;
        return (sb.size() == 0) && !m_occ && !m_busy;
    endfunction

    task automatic run_phase(input string nm, input int gap, input int rdy, input int slo, input int shi);
        int t;
        do_reset();
        for (int i = 0; i < N; i++) begin pos[i] = 0; exp_pos[i] = 0; end
        gap_pct = gap; rdy_pct = rdy; stall_lo = slo; stall_hi = shi;
        first_dv_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
        nout = 0; rdy2_cnt = 0; start_cyc = -1;
        phase_start = cyc + 1;
        drv_en = 1;
        t = 0;
        while (!phase_done() && t < 3000) begin @(posedge clock); #2; t++; end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL timeout_%s: phase still pending after %0d cycles, required drain", nm, t);
        end
        repeat (2) @(posedge clock);
        #2 drv_en = 0; in_valid = '0;
    endtask

    task automatic wait_ready(input int id, input string nm);
        int t = 0;
        do begin @(negedge clock); t++; end while (!in_ready[id] && t < 20);
        chk(nm, int'(in_ready), 1 << id);
    endtask

    task automatic send1(input int id, input logic [7:0] d, input string nm);
        @(posedge clock); #2;
        in_data[id*DW +: DW] = d; in_last[id] = 1'b1; in_valid[id] = 1'b1;
        wait_ready(id, nm);
        @(posedge clock); #2 in_valid[id] = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_data_last", int'(data_last), 0);
        chk("rst_data_id", int'(data_id), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        mon_en = 1;

        // single requester, latency and ready window
        clear_src(); add_pkt(2, 3, 'h11, 0);
        run_phase("single", 0, 100, -1, -1);
        chk("p1_latency", first_dv_cyc - start_cyc, 2);
        chk("p1_ready_cycles", rdy2_cnt, 3);
        chk("p1_beats", nout, 3);

        // fairness: everyone offers 1-beat packets carrying its id
        clear_src();
        for (int i = 0; i < N; i++) for (int k = 0; k < 6; k++) src_q[i].push_back({1'b1, 8'(i)});
        run_phase("fair", 0, 100, -1, -1);
        chk("p2_beats", nout, 24);
        chk("p2_spacing", last_out_cyc - first_out_cyc, 46);

        // atomicity: req0 4-beat packet while req1 waits
        clear_src(); add_pkt(0, 4, 'h40, 0); add_pkt(1, 2, 'h90, 0);
        run_phase("atomic", 0, 100, -1, -1);
        chk("p3_beats", nout, 6);

        // backpressure: 5 stalled cycles mid-packet
        clear_src(); add_pkt(0, 8, 'h01, 0);
        run_phase("stall", 0, 100, 4, 9);
        chk("p4_beats", nout, 8);

        // random traffic with gaps and random sink readiness
        for (int r = 0; r < 3; r++) begin
            clear_src();
            for (int i = 0; i < N; i++)
                for (int p = $urandom_range(1, 4); p > 0; p--) add_pkt(i, $urandom_range(1, 4), 0, 1);
            run_phase("random", 20 + 15 * r, 80 - 20 * r, -1, -1);
        end

        // directed: wrap-around search, pointer after wrap, reset mid-packet
        mon_en = 0;
        do_reset();
        data_ready = 1'b1;
        send1(1, 8'h55, "d_req1");
        send1(2, 8'h66, "d_req2");
        send1(1, 8'h77, "d_wrap_grant");      // pointer at 3, only req1 valid
        @(posedge clock); #2;
        in_data[0*DW +: DW] = 8'hC0; in_last[0] = 1'b1;
        in_data[2*DW +: DW] = 8'hA0; in_last[2] = 1'b0;
        in_valid = 4'b0101;
        wait_ready(2, "d_ptr_after_wrap");    // pointer at 2 favours req2 over req0
        @(posedge clock); #2;
        in_data[2*DW +: DW] = 8'hA1;
        reset = 1'b0;
        @(negedge clock);
        chk("d_first_beat", int'(data), 'hA0);
        chk("d_first_id", int'(data_id), 2);
        @(negedge clock);
        chk("d_rst_valid", int'(data_valid), 0);
        chk("d_rst_data", int'(data), 0);
        chk("d_rst_last", int'(data_last), 0);
        chk("d_rst_id", int'(data_id), 0);
        chk("d_rst_ready", int'(in_ready), 0);
        @(posedge clock); #2 reset = 1'b1;
        wait_ready(0, "d_post_rst_grant");
        begin
            int t = 0;
            do begin @(negedge clock); t++; end while (!data_valid && t < 20);
        end
        chk("d_post_rst_id", int'(data_id), 0);
        chk("d_post_rst_data", int'(data), 'hC0);
        chk("d_post_rst_last", int'(data_last), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_rr_arbiter.md
Name: rv_rr_arbiter

Overview:
- Round-robin arbiter that shares one ready/valid data stream among N_INPUTS ready/valid requesters.
- Grants are packet-atomic: once granted, a requester keeps the output until it transfers a beat with last=1.
- The output is registered. It connects directly to a ready/valid sink such as the stream input BFM, so several stimulus sources can drive one consumer.

Parameters:
- N_INPUTS, 4, number of requesters (2..16).
- DATA_WIDTH, 8, data width of each beat.
- ID_WIDTH, $clog2(N_INPUTS), width of the source-id field.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  reset is synchronous and active-low.
- in_data  input  N_INPUTS*DATA_WIDTH  requester i drives bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  N_INPUTS  per-requester valid.
- in_last  input  N_INPUTS  per-requester end-of-packet flag, qualified by in_valid.
- in_ready  output  N_INPUTS  per-requester ready.
- data  output  DATA_WIDTH  registered output beat.
- data_valid  output  1  output valid.
- data_last  output  1  output end-of-packet flag.
- data_id  output  ID_WIDTH  index of the requester that sourced the beat.
- data_ready  input  1  sink ready.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, grant=0, rr_ptr=0.
  - data_valid=0, data=0, data_last=0, data_id=0.
  - in_ready=0 is combinational from state, so it is 0 during reset.
- Reset asserted mid-packet aborts the packet. The output register is cleared and the partial beat is discarded. There is no recovery of the aborted packet.
- Handshake rules:
  - A transfer occurs on any edge where valid&&ready is high.
  - data, data_last and data_id hold stable while data_valid=1 and data_ready=0.
  - data_valid never drops without a transfer.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any in_valid bit is 1, the winner is the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... N_INPUTS-1, 0, ... (wrap).
  - Next edge: grant=winner, state=BUSY.
  - If no in_valid bit is 1, stay in IDLE.
  - in_ready=0 in IDLE.
- BUSY:
  - in_ready[grant] = (!data_valid || data_ready). All other in_ready bits are 0.
  - On an input transfer: the output register loads in_data[grant], in_last[grant] and grant; data_valid=1 next cycle.
  - On an output transfer with no simultaneous input transfer: data_valid=0 next cycle.
  - Simultaneous output transfer and input transfer: the register reloads and data_valid stays 1 (full throughput, 1 beat/cycle).
- Packet end:
  - An input transfer with in_last[grant]=1 moves state to IDLE and sets rr_ptr=(grant+1) mod N_INPUTS on the same edge.
  - The last beat may still be pending in the output register. The next arbitration proceeds anyway, but in_ready stays gated by register occupancy.
- Latency:
  - in_valid rising in IDLE at cycle 0 gives grant at edge 0, in_ready=1 in cycle 1, and data_valid=1 in cycle 2.
  - Between packets there is exactly one arbitration cycle (IDLE) of input-side bubble.
- A requester dropping in_valid mid-packet while granted is legal. The grant holds and the block waits indefinitely in BUSY.
- Single-beat packets (in_last=1 on the first beat) are legal and return to IDLE after one transfer.
- rr_ptr wraps from N_INPUTS-1 to 0. Changes to in_valid of non-granted requesters during BUSY have no effect.

Test Plan:
- Reset then one requester: after reset, in_valid[2]=1 with 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) and data_ready=1. Expect data_valid first in cycle 2, beats in order with data_id=2, data_last only on 0x33, in_ready[2] high for exactly 3 cycles.
- Round-robin fairness: all 4 requesters continuously offer 1-beat packets with data=id, data_ready=1. Expect data_id sequence 0,1,2,3,0,1,... with an output bubble every other cycle.
- Packet atomicity: req0 sends a 4-beat packet while req1 is valid throughout. Expect all 4 req0 beats contiguous before any id=1 beat; in_ready[1]=0 throughout req0's packet.
- Backpressure: data_ready=0 for 5 cycles mid-packet. Expect data, data_last and data_id stable, in_ready[grant]=0, no beat lost or duplicated (scoreboard compares 8 beats).
- Wrap and skip: rr_ptr=3 after req2 finishes, only req1 valid. Expect the search to wrap (3→0→1) and grant req1; next rr_ptr=2.
- Reset mid-packet: assert reset=0 on the 2nd beat of a 4-beat packet. Expect data_valid=0, in_ready all 0, state IDLE, rr_ptr=0; after release, req0 wins if valid.
